mem_wb_unit: RTL and testbench
==============================

Name: mem_wb_unit

Overview:
- Memory-access control and MEM/WB pipeline register, sitting directly downstream of the MEM stage's address/byte-enable logic.
- Drives the data-cache read/write handshake and stalls upstream until the cache responds.
- Aligns and sign/zero-extends load data using funct3 and the low two address bits.
- Registers the writeback result (rd, data, regwrite) for the register file.

Parameters:
- XLEN, 32: data and address width.
- RA_W, 5: register-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- valid_mem  in  1  instruction in MEM is valid.
- load_mem  in  1  instruction is a load.
- store_mem  in  1  instruction is a store.
- regwrite_mem  in  1  instruction writes rd.
- funct3_mem  in  3  load/store width code.
- rd_mem  in  RA_W  destination register.
- alu_buffered  in  XLEN  ALU result; writeback data for non-loads.
- addr_lo  in  2  low two address bits, from the MEM stage.
- dmem_resp  in  1  cache completes the current access this cycle.
- dmem_rdata  in  XLEN  cache read word, valid with dmem_resp.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- stall_mem  out  1  hold IF..MEM this cycle.
- wb_valid  out  1  WB register holds a valid instruction.
- wb_regwrite  out  1  write rd this cycle.
- wb_rd  out  RA_W  writeback register.
- wb_data  out  XLEN  writeback value.

Behaviour:
- FSM states are IDLE and WAIT. Reset (rst==0 at posedge) sets state=IDLE and wb_valid=0, wb_regwrite=0, wb_rd=0, wb_data=0.
- A memory op (memop) is valid_mem & (load_mem | store_mem).
- dmem_read = memop & load_mem, and dmem_write = memop & store_mem, both combinational in IDLE and WAIT.
- Requests stay asserted until dmem_resp; inputs are stable while stall_mem=1.
- stall_mem = memop & ~dmem_resp.
- IDLE to WAIT when memop & ~dmem_resp. IDLE stays IDLE when memop & dmem_resp (zero-wait hit).
- WAIT to IDLE on dmem_resp; otherwise WAIT stays WAIT.
- dmem_resp with no memop is ignored.
- WB register updates every cycle and is not gated by the stall:
  - stall_mem=1: capture a bubble (wb_valid=0, wb_regwrite=0; wb_rd and wb_data hold).
  - Completing load: wb_data = aligned dmem_rdata.
  - Store: wb_regwrite=0, wb_valid=1.
  - Non-memory valid op: wb_data = alu_buffered (one-cycle latency).
  - valid_mem=0: bubble.
- wb_regwrite = regwrite_mem & (rd_mem!=0) & not-store.
- Load alignment, byte lanes matching the store side:
  - lb/lbu (000/100): byte addr_lo, sign/zero-extended.
  - lh/lhu (001/101): bits[15:0] for addr_lo 00/01, bits[31:16] for 10/11, sign/zero-extended.
  - lw (010): full word.
  - Other funct3: full word.
- Reset mid-WAIT: state returns to IDLE. Requests drop once valid_mem deasserts upstream; no stale dmem_resp is accepted after reset.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- Defined: misaligned accesses are lw/sw with addr_lo!=00, or lh/lhu/sh with addr_lo==11. For these:
  - no dmem_read/dmem_write is raised and stall_mem=0;
  - the WB register captures wb_valid=1, wb_regwrite=0;
  - extra output misalign_err pulses high for that one cycle.
- Undefined: no check, no misalign_err port; misaligned accesses proceed with the lane rules above.

Decomposition:
- Shared package rv32i_types holds load_funct3_t/store_funct3_t (existing) and a new mem_wb_state_t enum {IDLE, WAIT}.
- Sub-module load_align: purely combinational; inputs funct3, addr_lo, rdata; output extended data. It is reused by any future forwarding path.

Test Plan:
- ALU op, alu_buffered=0x1234_5678, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x12345678; no dmem request.
- lb, addr_lo=11, rdata=0x80AA_BBCC, resp after 3 cycles -> stall_mem high 3 cycles with bubbles in WB; then wb_data=0xFFFFFF80.
- lhu, addr_lo=10, rdata=0x8001_7FFF, same-cycle resp -> stall_mem=0, state stays IDLE, wb_data=0x00008001.
- sw with resp after 2 cycles -> dmem_write high 3 cycles; then wb_valid=1, wb_regwrite=0.
- lw with rd=0 -> wb_regwrite=0. rst=0 asserted while in WAIT -> state IDLE and all WB outputs 0 next cycle.
- With MEM_MISALIGN_CHECK_EN defined: lw, addr_lo=01 -> no dmem_read, misalign_err=1 for one cycle, wb_regwrite=0.

Source files
------------

// File: rtl/mem_wb_unit_pkg.sv
// Shared RV32I types for the MEM/WB slice: load/store width codes and the memory-access FSM states.
// Also holds the misalignment classifier used when MEM_MISALIGN_CHECK_EN is defined.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_wb_state_t;

    // Word ops need a word-aligned address; halfword ops must not straddle the word boundary.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic       is_store,
                                           input logic [1:0] addr_lo);
        logic res;
        case (funct3)
            3'b010:  res = (addr_lo != 2'b00);
            3'b001:  res = (addr_lo == 2'b11);
            3'b101:  res = (!is_store) && (addr_lo == 2'b11);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_wb_unit_load_align.sv
// Combinational load-data lane selection and sign/zero extension.
// Kept standalone so a forwarding path can reuse the same alignment.
module load_align
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte/halfword lane, then extend by width code.
    always_comb begin
        w_byte   = rdata[{addr_lo, 3'b000} +: 8];
        w_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data_ext = rdata;
        case (load_funct3_t'(funct3))
            LB:      data_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            LBU:     data_ext = {{(XLEN-8){1'b0}}, w_byte};
            LH:      data_ext = {{(XLEN-16){w_half[15]}}, w_half};
            LHU:     data_ext = {{(XLEN-16){1'b0}}, w_half};
            LW:      data_ext = rdata;
            default: data_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_unit.sv
// Data-cache handshake control plus the MEM/WB pipeline register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_wb_unit
    import rv32i_types::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_mem,
    input  logic            load_mem,
    input  logic            store_mem,
    input  logic            regwrite_mem,
    input  logic [2:0]      funct3_mem,
    input  logic [RA_W-1:0] rd_mem,
    input  logic [XLEN-1:0] alu_buffered,
    input  logic [1:0]      addr_lo,
    input  logic            dmem_resp,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic            stall_mem,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic            misalign_err,
`endif
    output logic            wb_valid,
    output logic            wb_regwrite,
    output logic [RA_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data
);

    mem_wb_state_t   r_state;
    logic            w_memop;
    logic            w_misalign;
    logic            w_req;
    logic [XLEN-1:0] w_load_data;

    assign w_memop = valid_mem & (load_mem | store_mem);

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign   = w_memop & is_misaligned(funct3_mem, store_mem, addr_lo);
    assign misalign_err = w_misalign;
`else
    assign w_misalign   = 1'b0;
`endif

    // A trapped access never reaches the cache, so it neither requests nor stalls.
    assign w_req      = w_memop & ~w_misalign;
    assign dmem_read  = w_req & load_mem;
    assign dmem_write = w_req & store_mem;
    assign stall_mem  = w_req & ~dmem_resp;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .funct3   (funct3_mem),
        .addr_lo  (addr_lo),
        .rdata    (dmem_rdata),
        .data_ext (w_load_data)
    );

    // Access FSM: tracks whether the cache still owes a response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= (w_req && !dmem_resp) ? WAIT : IDLE;
                WAIT:    r_state <= dmem_resp ? IDLE : WAIT;
                default: r_state <= IDLE;
            endcase
        end
    end

    // WB register: loads every cycle; stall and empty slots become bubbles holding rd/data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else if (stall_mem) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
        end else if (w_misalign) begin
            wb_valid    <= 1'b1;
            wb_regwrite <= 1'b0;
            wb_rd       <= rd_mem;
            wb_data     <= alu_buffered;
        end else if (valid_mem) begin
            wb_valid    <= 1'b1;
            wb_regwrite <= regwrite_mem & (rd_mem != '0) & ~store_mem;
            wb_rd       <= rd_mem;
            wb_data     <= load_mem ? w_load_data : alu_buffered;
        end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_unit.sv
// Scoreboard bench for mem_wb_unit: expected WB contents queued per driven cycle, popped after the capture edge.
// Covers the misalignment trap when MEM_MISALIGN_CHECK_EN is defined.
module tb_mem_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_mem, load_mem, store_mem, regwrite_mem;
    logic [2:0]  funct3_mem;
    logic [4:0]  rd_mem;
    logic [31:0] alu_buffered;
    logic [1:0]  addr_lo;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read, dmem_write, stall_mem;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        state;
    } wb_exp_t;

    wb_exp_t     sb_q[$];
    logic [4:0]  m_rd   = 5'd0;
    logic [31:0] m_data = 32'd0;
    int          n_cmp  = 0;
    int          n_err  = 0;

    always #5 clk = ~clk;

    mem_wb_unit #(.XLEN(32), .RA_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_mem    (valid_mem),
        .load_mem     (load_mem),
        .store_mem    (store_mem),
        .regwrite_mem (regwrite_mem),
        .funct3_mem   (funct3_mem),
        .rd_mem       (rd_mem),
        .alu_buffered (alu_buffered),
        .addr_lo      (addr_lo),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .stall_mem    (stall_mem),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_err (misalign_err),
`endif
        .wb_valid     (wb_valid),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference lane/extension model, written from the width-code table.
    function automatic logic [31:0] exp_align(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rdata);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = rdata >> (32'(lo) * 32'd8);
        b  = sh[7:0];
        h  = (lo >= 2'd2) ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic exp_mis(input logic [2:0] f3, input logic st, input logic [1:0] lo);
`ifdef MEM_MISALIGN_CHECK_EN
        if (f3 == 3'b010) return lo != 2'b00;
        if (f3 == 3'b001) return lo == 2'b11;
        if (f3 == 3'b101 && !st) return lo == 2'b11;
`endif
        return 1'b0;
    endfunction

    // One clock with the currently driven inputs: check handshake, queue expected WB, then compare it.
    task automatic cycle(input logic resp, input logic [31:0] rdata);
        logic    memop, mis, req, e_stall;
        wb_exp_t e, got;
        dmem_resp  = resp;
        dmem_rdata = rdata;
        memop   = valid_mem & (load_mem | store_mem);
        mis     = memop & exp_mis(funct3_mem, store_mem, addr_lo);
        req     = memop & ~mis;
        e_stall = req & ~resp;
        e.state = e_stall;
        if (e_stall || !valid_mem) begin
            e.valid = 1'b0; e.regwrite = 1'b0; e.rd = m_rd; e.data = m_data;
        end else if (mis) begin
            e.valid = 1'b1; e.regwrite = 1'b0; e.rd = rd_mem; e.data = alu_buffered;
        end else begin
            e.valid    = 1'b1;
            e.regwrite = regwrite_mem & (rd_mem != 5'd0) & ~store_mem;
            e.rd       = rd_mem;
            e.data     = load_mem ? exp_align(funct3_mem, addr_lo, rdata) : alu_buffered;
        end
        m_rd   = e.rd;
        m_data = e.data;
        sb_q.push_back(e);
        @(negedge clk);
        check_eq("dmem_read",  32'(dmem_read),  32'(req & load_mem));
        check_eq("dmem_write", 32'(dmem_write), 32'(req & store_mem));
        check_eq("stall_mem",  32'(stall_mem),  32'(e_stall));
`ifdef MEM_MISALIGN_CHECK_EN
        check_eq("misalign_err", 32'(misalign_err), 32'(mis));
`endif
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check_eq("wb_valid",    32'(wb_valid),    32'(got.valid));
            check_eq("wb_regwrite", 32'(wb_regwrite), 32'(got.regwrite));
            check_eq("wb_rd",       32'(wb_rd),       32'(got.rd));
            check_eq("wb_data",     wb_data,          got.data);
            check_eq("state",       32'(dut.r_state), 32'(got.state));
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic rw,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [1:0] lo);
        valid_mem = v; load_mem = ld; store_mem = st; regwrite_mem = rw;
        funct3_mem = f3; rd_mem = rd; alu_buffered = alu; addr_lo = lo;
    endtask

    // Hold an op for 'wait_cyc' stall cycles, cache responding on the last cycle.
    task automatic do_op(input logic v, input logic ld, input logic st, input logic rw,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [1:0] lo, input logic [31:0] rdata, input int wait_cyc);
        drive(v, ld, st, rw, f3, rd, alu, lo);
        for (int c = 0; c <= wait_cyc; c++) begin
            cycle(c == wait_cyc, (c == wait_cyc) ? rdata : 32'hDEAD_BEEF);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 2'b00);
        dmem_resp = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_data",  wb_data,       32'd0);
        check_eq("rst_state",    32'(dut.r_state), 32'd0);
        rst = 1'b1;

        do_op(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd5, 32'h1234_5678, 2'b00, 32'h0, 0);
        do_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 5'd7, 32'h0000_0013, 2'b11, 32'h80AA_BBCC, 3);
        do_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 5'd8, 32'h0000_0012, 2'b10, 32'h8001_7FFF, 0);
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd9, 32'h0000_0020, 2'b00, 32'h0, 2);
        do_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd0, 32'h0000_0024, 2'b00, 32'hCAFE_F00D, 1);
        do_op(1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h0000_0028, 2'b00, 32'h1111_2222, 0);
        do_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 5'd10, 32'h0000_0031, 2'b01, 32'h0000_8123, 0);
        do_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 5'd11, 32'h0000_0035, 2'b01, 32'h0000_7F00, 1);
        do_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 5'd12, 32'h0000_0038, 2'b00, 32'h1234_56FF, 0);
        do_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd13, 32'h0000_003C, 2'b00, 32'hA5A5_5A5A, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        do_op(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd14, 32'h0000_0041, 2'b01, 32'h0, 0);
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 5'd15, 32'h0000_0043, 2'b11, 32'h0, 0);
`endif

        // Reset asserted while a load waits on the cache.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd6, 32'h0000_0050, 2'b00);
        cycle(1'b0, 32'hDEAD_BEEF);
        cycle(1'b0, 32'hDEAD_BEEF);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rstw_state",    32'(dut.r_state), 32'd0);
        check_eq("rstw_valid",    32'(wb_valid),    32'd0);
        check_eq("rstw_regwrite", 32'(wb_regwrite), 32'd0);
        check_eq("rstw_rd",       32'(wb_rd),       32'd0);
        check_eq("rstw_data",     wb_data,          32'd0);
        rst = 1'b1;
        m_rd = 5'd0; m_data = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 2'b00);
        cycle(1'b1, 32'h7777_7777);
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd31, 32'hFEDC_BA98, 2'b00, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
